// File: rtl/decoder_scan_ctrl_if.sv
// Signal bundle between the scan sequencer and whoever commands it.
//
// There is no valid/ready handshake on this bundle. run and mask are level
// signals owned by the master; the sequencer samples them only while idle and
// on the last cycle of each channel dwell, so they may change at any time.
// en/a/b/frame_done/idle are registered outputs of the sequencer.
// scan_state mirrors the sequencer FSM register for observation.
//
// Signals:
//   run         master -> slave  1 = keep scanning
//   mask        master -> slave  per-channel enable, bit i = channel i
//   en          slave -> master  decoder enable
//   a, b        slave -> master  channel index {a,b}, a = MSB
//   frame_done  slave -> master  1-cycle pulse when channel selection wraps
//   idle        slave -> master  1 while the sequencer is idle
//   scan_state  slave -> master  FSM state (0 idle, 1 blank, 2 drive)
interface decoder_scan_ctrl_if;
    logic       run;
    logic [3:0] mask;
    logic       en;
    logic       a;
    logic       b;
    logic       frame_done;
    logic       idle;
    logic [1:0] scan_state;

    modport master (
        output run, mask,
        input  en, a, b, frame_done, idle, scan_state
    );

    modport slave (
        input  run, mask,
        output en, a, b, frame_done, idle, scan_state
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Upstream sequencer for a 2-to-4 enable decoder. Time-multiplexes four
// channels round-robin over those enabled in mask: each visit is BLANK cycles
// with en low (anti-ghosting) followed by DWELL cycles with en high.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   scan   decoder_scan_ctrl_if.slave: run/mask in; en, a, b, frame_done,
//          idle, scan_state out (all registered)
module decoder_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int BLANK = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_scan_ctrl_if.slave   scan
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // Counters run down to zero; zero marks the last cycle of a phase.
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_M1 = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       ch, ch_n;
    logic [1:0]       nxt;
    logic             en_q, en_n;
    logic             fd_q, fd_n;
    logic             idle_q, idle_n;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_ch = 2'(i);
        end
    endfunction

    // First enabled channel strictly after cur, wrapping. Offset 4 wraps back
    // to cur itself, which covers the single-channel case.
    function automatic logic [1:0] next_ch(input logic [3:0] m,
                                           input logic [1:0] cur);
        logic [1:0] idx;
        next_ch = cur;
        for (int i = 4; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (m[idx]) next_ch = idx;
        end
    endfunction

    assign nxt = next_ch(scan.mask, ch);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ch_n    = ch;
        fd_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (scan.run && (scan.mask != 4'd0)) begin
                    ch_n = lowest_ch(scan.mask);
                    if (BLANK > 0) begin
                        state_n = S_BLANK;
                        cnt_n   = BLANK_M1;
                    end else begin
                        state_n = S_DRIVE;
                        cnt_n   = DWELL_M1;
                    end
                end
            end
            S_BLANK: begin
                if (cnt == '0) begin
                    state_n = S_DRIVE;
                    cnt_n   = DWELL_M1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DRIVE: begin
                if (cnt == '0) begin
                    if (!scan.run || (scan.mask == 4'd0)) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        ch_n = nxt;
                        // Wrap (including re-selecting the same channel) ends a frame.
                        fd_n = (nxt <= ch);
                        if (BLANK > 0) begin
                            state_n = S_BLANK;
                            cnt_n   = BLANK_M1;
                        end else begin
                            state_n = S_DRIVE;
                            cnt_n   = DWELL_M1;
                        end
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        en_n   = (state_n == S_DRIVE);
        idle_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ch     <= 2'd0;
            en_q   <= 1'b0;
            fd_q   <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ch     <= ch_n;
            en_q   <= en_n;
            fd_q   <= fd_n;
            idle_q <= idle_n;
        end
    end

    assign scan.en         = en_q;
    assign scan.a          = ch[1];
    assign scan.b          = ch[0];
    assign scan.frame_done = fd_q;
    assign scan.idle       = idle_q;
    assign scan.scan_state = state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: two instances (DWELL=4/BLANK=1 and
// DWELL=3/BLANK=0) driven with the same run/mask, compared every cycle with a
// visit-position model derived from the channel scanning rules.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run_v;
    logic [3:0] mask_v;

    int checks = 0;
    int errors = 0;

    decoder_scan_ctrl_if sif0 ();
    decoder_scan_ctrl_if sif1 ();

    assign sif0.run  = run_v;
    assign sif0.mask = mask_v;
    assign sif1.run  = run_v;
    assign sif1.mask = mask_v;

    decoder_scan_ctrl #(.DWELL(4), .BLANK(1), .CNT_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (sif0.slave)
    );

    decoder_scan_ctrl #(.DWELL(3), .BLANK(0), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .scan  (sif1.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: per instance, whether scanning, current channel and
    // position inside the current visit (blank cycles first, then dwell)
    int p_dwell[2] = '{4, 3};
    int p_blank[2] = '{1, 0};
    bit m_act[2];
    int m_ch[2];
    int m_pos[2];
    bit m_fd[2];

    logic [4:0] exp_q[$];
    int fd_cnt0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0;
            m_ch[k]  = 0;
            m_pos[k] = 0;
            m_fd[k]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input int k);
        int n;
        m_fd[k] = 0;
        if (!m_act[k]) begin
            if (run_v && mask_v != 4'd0) begin
                n = -1;
                for (int i = 0; i < 4 && n < 0; i++) if (mask_v[i]) n = i;
                m_act[k] = 1;
                m_ch[k]  = n;
                m_pos[k] = 0;
            end
        end else if (m_pos[k] == p_blank[k] + p_dwell[k] - 1) begin
            if (!run_v || mask_v == 4'd0) begin
                m_act[k] = 0;
                m_pos[k] = 0;
            end else begin
                n = -1;
                for (int i = 1; i <= 4 && n < 0; i++)
                    if (mask_v[(m_ch[k] + i) % 4]) n = (m_ch[k] + i) % 4;
                m_fd[k]  = (n <= m_ch[k]);
                m_ch[k]  = n;
                m_pos[k] = 0;
            end
        end else begin
            m_pos[k] = m_pos[k] + 1;
        end
    endtask

    function automatic logic [4:0] model_out(input int k);
        logic [1:0] c;
        c = 2'(m_ch[k]);
        return {~m_act[k], m_fd[k], (m_act[k] && m_pos[k] >= p_blank[k]), c};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // one clock: model consumes the inputs seen at the edge, DUT sampled 1ns later
    task automatic step();
        logic [4:0] e;
        @(posedge clk);
        model_step(0);
        model_step(1);
        exp_q.push_back(model_out(0));
        exp_q.push_back(model_out(1));
        #1;
        e = exp_q.pop_front();
        chk("dut0_out", {3'b0, sif0.idle, sif0.frame_done, sif0.en, sif0.a, sif0.b}, {3'b0, e});
        e = exp_q.pop_front();
        chk("dut1_out", {3'b0, sif1.idle, sif1.frame_done, sif1.en, sif1.a, sif1.b}, {3'b0, e});
        if (sif0.frame_done) fd_cnt0++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n  = 1'b0;
        run_v  = 1'b0;
        mask_v = 4'd0;
        model_reset();
        @(negedge clk);
        chk("reset0", {3'b0, sif0.idle, sif0.frame_done, sif0.en, sif0.a, sif0.b}, 8'b0001_0000);
        chk("reset1", {3'b0, sif1.idle, sif1.frame_done, sif1.en, sif1.a, sif1.b}, 8'b0001_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // idle with run low, then all four channels
        steps(3);
        run_v  = 1'b1;
        mask_v = 4'b1111;
        steps(10);
        fd_cnt0 = 0;
        steps(40);
        chk("frame_rate_1111", 8'(fd_cnt0), 8'd2);

        // two channels, then a single channel
        mask_v = 4'b1010;
        steps(10);
        fd_cnt0 = 0;
        steps(30);
        chk("frame_rate_1010", 8'(fd_cnt0), 8'd3);
        mask_v = 4'b0100;
        steps(10);
        fd_cnt0 = 0;
        steps(25);
        chk("frame_rate_0100", 8'(fd_cnt0), 8'd5);

        // stop mid-dwell, then run with empty mask
        mask_v = 4'b1111;
        steps(7);
        run_v = 1'b0;
        steps(10);
        run_v  = 1'b1;
        mask_v = 4'b0000;
        steps(8);
        chk("idle_on_empty_mask", {7'b0, sif0.idle}, 8'd1);

        // narrow the mask while a channel is being driven
        mask_v = 4'b1111;
        steps(8);
        mask_v = 4'b0001;
        steps(20);

        // random run/mask
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) mask_v = 4'($urandom_range(0, 15));
            run_v = ($urandom_range(0, 15) != 0);
            step();
        end

        // asynchronous reset in the middle of a dwell
        run_v  = 1'b1;
        mask_v = 4'b1111;
        for (int i = 0; i < 30 && !sif0.en; i++) step();
        chk("reach_drive", {7'b0, sif0.en}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst0", {3'b0, sif0.idle, sif0.frame_done, sif0.en, sif0.a, sif0.b}, 8'b0001_0000);
        chk("async_rst1", {3'b0, sif1.idle, sif1.frame_done, sif1.en, sif1.a, sif1.b}, 8'b0001_0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        steps(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
